// File: rtl/score_scan_display.sv
// Saturating BCD score accumulator driven by collision edges, plus a multiplexed seven-segment scanner.
// Optional build macro SCORE_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module score_scan_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  collision,
  input  logic [3:0]            points,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  overflow,
  output logic [6:0]            seven_seg_display,
  output logic [DIGITS-1:0]     an
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic                coll_q;
  logic [4*DIGITS-1:0] score_q, score_d;
  logic                ovf_q, ovf_d;
  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                evt, tick;
  logic [3:0]          pts;
  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] sum;
  logic [6:0]          digit_seg [DIGITS];

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = 7'b1111111;
    endcase
  endfunction

  // coll_q resets high so a level already high at reset release is not an edge
  assign evt      = collision & ~coll_q;
  assign pts      = (points > 4'd9) ? 4'd9 : points;
  assign carry[0] = 1'b0;
  assign tick     = (div_q == DW'(REFRESH_DIV - 1));

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [4:0] raw;
      assign raw = {1'b0, score_q[4*gi +: 4]} + {1'b0, (gi == 0) ? pts : 4'd0} + {4'd0, carry[gi]};
      assign carry[gi+1]    = (raw > 5'd9);
      assign sum[4*gi +: 4] = carry[gi+1] ? 4'(raw - 5'd10) : raw[3:0];
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign digit_seg[gi] = bcd_to_seg(score_q[3:0]);
      end else begin : g_msd
        assign digit_seg[gi] = (score_q[4*DIGITS-1:4*gi] == '0) ? 7'b1111111
                                                               : bcd_to_seg(score_q[4*gi +: 4]);
      end
`else
      assign digit_seg[gi] = bcd_to_seg(score_q[4*gi +: 4]);
`endif
    end
  endgenerate

  always_comb begin
    score_d = score_q;
    ovf_d   = ovf_q;
    if (clear) begin
      score_d = '0;
      ovf_d   = 1'b0;
    end else if (evt) begin
      if (carry[DIGITS]) begin
        score_d = ALL_NINES;
        ovf_d   = 1'b1;
      end else begin
        score_d = sum;
      end
    end

    div_d = tick ? '0 : div_q + DW'(1);
    idx_d = idx_q;
    an_d  = an_q;
    seg_d = seg_q;
    // Segments latch the pre-update score of the newly selected digit
    if (tick) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      an_d  = ~(DIGITS'(1) << idx_d);
      seg_d = digit_seg[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q  <= 1'b1;
      score_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= '0;
      idx_q   <= IW'(DIGITS - 1);
      an_q    <= '1;
      seg_q   <= 7'b1111111;
    end else begin
      coll_q  <= collision;
      score_q <= score_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign score_bcd         = score_q;
  assign overflow          = ovf_q;
  assign seven_seg_display = seg_q;
  assign an                = an_q;

endmodule

// File: tb/tb_score_scan_display.sv
// Bench for score_scan_display (DIGITS=4, REFRESH_DIV=4): directed scenarios plus random traffic
// compared every cycle against an integer-arithmetic reference model.
module tb_score_scan_display;
  localparam int D = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        collision = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  points = 4'd0;
  logic [15:0] score_bcd;
  logic        overflow;
  logic [6:0]  seven_seg_display;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  int         m_score;
  bit         m_ovf, m_prev, m_ticked;
  int         m_div, m_scan;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  score_scan_display #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .collision(collision), .points(points), .clear(clear),
    .score_bcd(score_bcd), .overflow(overflow),
    .seven_seg_display(seven_seg_display), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] disp(input int v, input int k);
    int p, dig;
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    dig = (v / p) % 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    if (k >= 1 && v < p) return 7'b1111111;
`endif
    return tbl[dig];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int p;
    if (rst) begin
      m_score = 0; m_ovf = 0; m_prev = 1; m_div = 0; m_scan = D - 1;
      m_an = 4'hF; m_seg = 7'h7F; m_ticked = 0;
    end else begin
      if (m_div == R - 1) begin
        m_div = 0;
        m_scan = (m_scan + 1) % D;
        m_an = ~(4'(1) << m_scan);
        m_seg = disp(m_score, m_scan);
        m_ticked = 1;
      end else begin
        m_div++;
      end
      if (clear) begin
        m_score = 0; m_ovf = 0;
      end else if (collision && !m_prev) begin
        p = (points > 9) ? 9 : int'(points);
        if (m_score + p > 9999) begin
          m_score = 9999; m_ovf = 1;
        end else begin
          m_score = m_score + p;
        end
      end
      m_prev = collision;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("score", 32'(score_bcd), 32'(to_bcd(m_score)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("an", 32'(an), 32'(m_an));
    chk("seg", 32'(seven_seg_display), 32'(m_seg));
    if (m_ticked) chk("an_onehot", 32'($countones(~an)), 32'd1);
  endtask

  task automatic evt(input logic [3:0] p);
    collision = 1'b1; points = p; cyc();
    collision = 1'b0; cyc();
  endtask

  initial begin
    // Reset and reset-state checks
    rst = 1'b1; cyc(); cyc();
    chk("rst_score", 32'(score_bcd), 32'h0);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seven_seg_display), 32'h7F);
    rst = 1'b0;
    for (int i = 0; i < R; i++) cyc();
    chk("first_tick_an", 32'(an), 32'b1110);

    // Three events of 7
    for (int i = 0; i < 3; i++) evt(4'd7);
    chk("req028_score", 32'(score_bcd), 32'h0021);
    chk("req028_ovf", 32'(overflow), 32'd0);

    // Load 9995 then saturate, then clear
    clear = 1'b1; cyc(); clear = 1'b0;
    for (int i = 0; i < 1110; i++) evt(4'd9);
    evt(4'd5);
    chk("load_9995", 32'(score_bcd), 32'h9995);
    evt(4'd5);
    chk("sat_score", 32'(score_bcd), 32'h9999);
    chk("sat_ovf", 32'(overflow), 32'd1);
    evt(4'd0);
    chk("full_zero_pts", 32'(score_bcd), 32'h9999);
    evt(4'd15);
    chk("sat_again", 32'(score_bcd), 32'h9999);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear_score", 32'(score_bcd), 32'h0);
    chk("clear_ovf", 32'(overflow), 32'd0);

    // Held collision counts once; clamped points
    collision = 1'b1; points = 4'd1;
    for (int i = 0; i < 20; i++) cyc();
    chk("held_once", 32'(score_bcd), 32'h0001);
    collision = 1'b0; cyc();
    evt(4'd12);
    chk("clamp_12", 32'(score_bcd), 32'h0010);

    // Clear beats simultaneous event
    clear = 1'b1; cyc(); clear = 1'b0;
    for (int i = 0; i < 4; i++) evt(4'd9);
    evt(4'd6);
    chk("score_0042", 32'(score_bcd), 32'h0042);
    clear = 1'b1; collision = 1'b1; points = 4'd5; cyc();
    clear = 1'b0; collision = 1'b0; cyc();
    chk("clear_wins", 32'(score_bcd), 32'h0);

    // Score 0007 scan pattern
    evt(4'd7);
    for (int i = 0; i < 2*R; i++) cyc();
    for (int i = 0; i < 8*R; i++) begin
      cyc();
      if (an == 4'b1110) chk("seg_d0", 32'(seven_seg_display), 32'b1111000);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      else chk("seg_hi_blank", 32'(seven_seg_display), 32'b1111111);
`else
      else chk("seg_hi_zero", 32'(seven_seg_display), 32'b1000000);
`endif
    end

    // Reset right after an event, collision still high across release
    clear = 1'b1; cyc(); clear = 1'b0;
    for (int i = 0; i < 5; i++) evt(4'd9);
    evt(4'd5);
    chk("score_0050", 32'(score_bcd), 32'h0050);
    collision = 1'b1; points = 4'd3; cyc();
    rst = 1'b1; cyc();
    chk("midrst_score", 32'(score_bcd), 32'h0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seven_seg_display), 32'h7F);
    rst = 1'b0;
    for (int i = 0; i < R; i++) cyc();
    chk("midrst_tick_an", 32'(an), 32'b1110);
    chk("no_evt_after_rst", 32'(score_bcd), 32'h0);
    collision = 1'b0; cyc();

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      collision = 1'($urandom_range(0, 1));
      points    = 4'($urandom_range(0, 15));
      clear     = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b0; clear = 1'b0; collision = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_scan_display.md
SCORE_SCAN_DISPLAY -- requirements
Module: score_scan_display

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD score digits and anodes (legal 2..8).
REQ-002 Parameter REFRESH_DIV, default 100000, clk cycles per digit-scan step (legal >= 2).
REQ-003 clk  input  1  system clock (100 MHz); single clock domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 collision  input  1  score event, level; the rising edge counts as one event.
REQ-006 points  input  4  BCD increment applied per event; values 10..15 clamp to 9.
REQ-007 clear  input  1  synchronous score clear, active-high.
REQ-008 score_bcd  output  4*DIGITS  current score, digit 0 in bits [3:0].
REQ-009 overflow  output  1  sticky saturation flag.
REQ-010 seven_seg_display  output  7  active-low segments, bit0=a ... bit6=g.
REQ-011 an  output  DIGITS  active-low one-hot anode; an[0] is the rightmost digit (digit 0).

Function
REQ-012 Collision edge detection uses a 1-cycle registered copy; event = collision & ~collision_q.
REQ-013 On an event, score_bcd shall update on the next clk edge to score + clamp(points), with decimal carry rippling through all DIGITS in that same cycle.
REQ-014 A carry out of digit DIGITS-1 shall saturate score_bcd to all 9s and set overflow; overflow stays set until rst or clear.
REQ-015 When score_bcd is all 9s, an event with points=0 shall leave the score unchanged and overflow unchanged.
REQ-016 clear shall zero score_bcd and overflow on the next edge; clear and an event in the same cycle -> clear wins, event discarded.
REQ-017 A holding collision high shall produce exactly one event; collision high during and after rst release shall not produce an event until it falls and rises again.
REQ-018 The divider counts 0..REFRESH_DIV-1 and wraps; the scan tick is the cycle in which it equals REFRESH_DIV-1.
REQ-019 On each tick, the scan index advances by 1, wrapping DIGITS-1 -> 0; an and seven_seg_display register the anode and pattern for the new index on the same edge.
REQ-020 Patterns (bit6..bit0): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
REQ-021 The displayed digit reflects score_bcd sampled at the tick; score changes between ticks appear on that digit's next visit.
REQ-022 Exactly one an bit is low at all times after the first tick.

Reset
REQ-023 rst shall set score_bcd=0, overflow=0, divider=0, scan index=DIGITS-1, an=all ones, seven_seg_display=1111111, collision_q=1.
REQ-024 rst asserted mid-scan or mid-event shall override all other inputs in that cycle.
REQ-025 The first tick after rst release (REFRESH_DIV cycles later) shall select digit 0 (an[0]=0).

Configuration
REQ-026 Macro SCORE_LEADING_ZERO_BLANK_EN: when defined, digit k (k>=1) displays blank if digit k and all higher digits are 0; digit 0 always displays its value.
REQ-027 Without SCORE_LEADING_ZERO_BLANK_EN, every digit displays its BCD value including leading zeros; an sequencing is identical in both builds.

Verification (DIGITS=4, REFRESH_DIV=4)
REQ-028 rst, then 3 collision edges with points=7 -> score_bcd=16'h0021, overflow=0.
REQ-029 Load 9995 via events, then event points=5 -> score_bcd=16'h9999, overflow=1; clear -> 16'h0000, overflow=0.
REQ-030 collision held high 20 cycles with points=1 -> score increments by exactly 1; points=12 on next edge -> adds 9.
REQ-031 clear and collision edge same cycle with score 0042 -> score_bcd=0, no increment.
REQ-032 Score 0007, observe 8 ticks -> an sequence 1110,1101,1011,0111 repeated; seg on an[0]=1111000; higher digits 1000000 without macro, 1111111 with SCORE_LEADING_ZERO_BLANK_EN.
REQ-033 rst asserted on the cycle after an event with score 0050 -> all outputs at reset values next edge; first tick selects an=1110.
